enc_input_cond: RTL and testbench

//  Conditions raw quadrature encoder lines (A/B, per channel) before the encoder

---
 rtl/enc_input_cond_pkg.sv | 33 +++
 rtl/enc_input_cond_line_filter.sv | 60 ++++++
 rtl/enc_input_cond.sv | 139 +++++++++++++
 tb/tb_enc_input_cond.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/enc_input_cond_pkg.sv
// Shared constants, state encodings and helpers for the encoder input conditioner.
package enc_input_cond_pkg;

  localparam int unsigned NUM_CHANNELS = 2;

  // Register map: [15:12] block select, [7:4] channel, [3:0] offset
  localparam logic [3:0] ADDR_MAIN    = 4'h2;
  localparam logic [3:0] OFF_ENC_STAT = 4'h8;
  localparam logic [3:0] OFF_ENC_FILT = 4'h9;

  localparam int unsigned GLITCH_W  = 16;
  localparam int unsigned ILLEGAL_W = 8;

  // Start-up sequencer states
  localparam logic [1:0] S_INIT = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;

  typedef struct packed {
    logic                 sticky;
    logic [ILLEGAL_W-1:0] illegal_cnt;
    logic [GLITCH_W-1:0]  glitch_cnt;
  } enc_stat_t;

  // Saturating add of a 0..3 increment to a glitch counter
  function automatic logic [GLITCH_W-1:0] sat_add_glitch(input logic [GLITCH_W-1:0] base,
                                                          input logic [1:0]          inc);
    logic [GLITCH_W:0] sum;
    sum = {1'b0, base} + {{(GLITCH_W-1){1'b0}}, inc};
    return sum[GLITCH_W] ? '1 : sum[GLITCH_W-1:0];
  endfunction

endpackage

// File: rtl/enc_input_cond_line_filter.sv
// One encoder line: 2-FF synchroniser followed by a persistence filter.
// upd/glitch flag what the filter does on the coming edge so the parent can
// account for events on that same edge.
module enc_line_filter
  import enc_input_cond_pkg::*;
#(
  parameter int unsigned FILT_W = 4
) (
  input  logic              sysclk,
  input  logic              reset,
  input  logic              raw,
  input  logic              load,
  input  logic              run,
  input  logic [FILT_W-1:0] filt_len,
  output logic              filt,
  output logic              upd,
  output logic              glitch
);

  logic              sync1;
  logic              sync2;
  logic [FILT_W-1:0] cnt;

  assign upd    = run && (sync2 != filt) && (cnt >= filt_len);
  assign glitch = run && (sync2 == filt) && (cnt != '0);

  // Two-stage synchroniser for the asynchronous raw line
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Persistence counter: accept a new level only after it has held for filt_len edges
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      filt <= 1'b0;
      cnt  <= '0;
    end else if (load) begin
      filt <= sync2;
      cnt  <= '0;
    end else if (run) begin
      if (sync2 != filt) begin
        if (cnt >= filt_len) begin
          filt <= sync2;
          cnt  <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/enc_input_cond.sv
// Encoder input conditioner: start-up sequencer, per-line filters, illegal
// A/B transition detection, saturating status counters and register access.
module enc_input_cond
  import enc_input_cond_pkg::*;
#(
  parameter int unsigned       NUM_CH       = NUM_CHANNELS,
  parameter int unsigned       FILT_W       = 4,
  parameter logic [FILT_W-1:0] FILT_DEFAULT = FILT_W'(7)
) (
  input  logic          sysclk,
  input  logic          reset,
  input  logic [1:NUM_CH] enc_a_raw,
  input  logic [1:NUM_CH] enc_b_raw,
  output logic [1:NUM_CH] enc_a_filt,
  output logic [1:NUM_CH] enc_b_filt,
  output logic [1:NUM_CH] enc_err,
  input  logic [15:0]   reg_raddr,
  input  logic [15:0]   reg_waddr,
  output logic [31:0]   reg_rdata,
  input  logic [31:0]   reg_wdata,
  input  logic          reg_wen
);

  logic [1:0]        state;
  logic              init_cnt;
  logic              load;
  logic              run;
  logic [FILT_W-1:0] filt_len;
  logic              w_main;
  logic              stat_wr;
  logic              filt_wr;
  enc_stat_t         stat [1:NUM_CH];
  logic              unused_ok;

  assign load = (state == S_LOAD);
  assign run  = (state == S_RUN);

  assign w_main  = reg_wen && (reg_waddr[15:12] == ADDR_MAIN);
  assign stat_wr = w_main && (reg_waddr[3:0] == OFF_ENC_STAT);
  assign filt_wr = w_main && (reg_waddr[3:0] == OFF_ENC_FILT) && (reg_waddr[7:4] == 4'h0);

  assign unused_ok = ^{reg_raddr[11:8], reg_waddr[11:8], reg_wdata[31:FILT_W]};

  // Start-up: two cycles for the synchronisers to fill, one cycle to preload filters
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      state    <= S_INIT;
      init_cnt <= 1'b0;
    end else begin
      case (state)
        S_INIT: begin
          init_cnt <= 1'b1;
          if (init_cnt) state <= S_LOAD;
        end
        S_LOAD:  state <= S_RUN;
        default: state <= S_RUN;
      endcase
    end
  end

  // Filter length register, shared by every line
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) filt_len <= FILT_DEFAULT;
    else if (filt_wr) filt_len <= reg_wdata[FILT_W-1:0];
  end

  for (genvar ch = 1; ch <= NUM_CH; ch++) begin : g_ch
    logic      upd_a, upd_b, gl_a, gl_b;
    logic      illegal, clr, err_q;
    enc_stat_t stat_q, stat_nxt;

    enc_line_filter #(.FILT_W(FILT_W)) u_filt_a (
      .sysclk   (sysclk),
      .reset    (reset),
      .raw      (enc_a_raw[ch]),
      .load     (load),
      .run      (run),
      .filt_len (filt_len),
      .filt     (enc_a_filt[ch]),
      .upd      (upd_a),
      .glitch   (gl_a)
    );

    enc_line_filter #(.FILT_W(FILT_W)) u_filt_b (
      .sysclk   (sysclk),
      .reset    (reset),
      .raw      (enc_b_raw[ch]),
      .load     (load),
      .run      (run),
      .filt_len (filt_len),
      .filt     (enc_b_filt[ch]),
      .upd      (upd_b),
      .glitch   (gl_b)
    );

    assign illegal = upd_a && upd_b;
    assign clr     = stat_wr && (reg_waddr[7:4] == 4'(ch)) && reg_wdata[0];

    // Clear zeroes the base value first so an event on the same edge is still counted
    always_comb begin
      stat_nxt = clr ? '0 : stat_q;
      stat_nxt.glitch_cnt = sat_add_glitch(stat_nxt.glitch_cnt, {1'b0, gl_a} + {1'b0, gl_b});
      if (illegal) begin
        stat_nxt.sticky = 1'b1;
        if (stat_nxt.illegal_cnt != '1) stat_nxt.illegal_cnt = stat_nxt.illegal_cnt + 1'b1;
      end
    end

    // Status counters and one-cycle illegal-transition strobe
    always_ff @(posedge sysclk or posedge reset) begin
      if (reset) begin
        stat_q <= '0;
        err_q  <= 1'b0;
      end else begin
        stat_q <= stat_nxt;
        err_q  <= illegal;
      end
    end

    assign enc_err[ch] = err_q;
    assign stat[ch]    = stat_q;
  end

  // Combinational register read decode
  always_comb begin
    reg_rdata = '0;
    if (reg_raddr[15:12] == ADDR_MAIN) begin
      if ((reg_raddr[3:0] == OFF_ENC_FILT) && (reg_raddr[7:4] == 4'h0)) begin
        reg_rdata = 32'(filt_len);
      end else if (reg_raddr[3:0] == OFF_ENC_STAT) begin
        for (int unsigned ch = 1; ch <= NUM_CH; ch++) begin
          if (reg_raddr[7:4] == 4'(ch))
            reg_rdata = {stat[ch].sticky, 7'b0, stat[ch].illegal_cnt, stat[ch].glitch_cnt};
        end
      end
    end
  end

endmodule

// File: tb/tb_enc_input_cond.sv
// Directed bench for enc_input_cond with hand-computed expectations.
module tb_enc_input_cond;
  import enc_input_cond_pkg::*;

  localparam int unsigned NCH = 2;

  logic            sysclk = 1'b0;
  logic            reset;
  logic [1:NCH]    enc_a_raw, enc_b_raw;
  logic [1:NCH]    enc_a_filt, enc_b_filt, enc_err;
  logic [15:0]     reg_raddr, reg_waddr;
  logic [31:0]     reg_rdata, reg_wdata;
  logic            reg_wen;

  int n_vec = 0;
  int n_err = 0;

  always #5 sysclk = ~sysclk;

  enc_input_cond #(.NUM_CH(NCH), .FILT_W(4), .FILT_DEFAULT(4'd7)) dut (
    .sysclk     (sysclk),
    .reset      (reset),
    .enc_a_raw  (enc_a_raw),
    .enc_b_raw  (enc_b_raw),
    .enc_a_filt (enc_a_filt),
    .enc_b_filt (enc_b_filt),
    .enc_err    (enc_err),
    .reg_raddr  (reg_raddr),
    .reg_waddr  (reg_waddr),
    .reg_rdata  (reg_rdata),
    .reg_wdata  (reg_wdata),
    .reg_wen    (reg_wen)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge sysclk);
    #1;
  endtask

  function automatic logic [15:0] addr(input logic [3:0] ch, input logic [3:0] off);
    return {ADDR_MAIN, 4'h0, ch, off};
  endfunction

  task automatic chk_reg(input string tag, input logic [3:0] ch, input logic [3:0] off,
                         input logic [31:0] exp);
    reg_raddr = addr(ch, off);
    #1;
    check(tag, reg_rdata, exp);
  endtask

  task automatic wr(input logic [3:0] ch, input logic [3:0] off, input logic [31:0] d);
    reg_waddr = addr(ch, off);
    reg_wdata = d;
    reg_wen   = 1'b1;
    tick;
    reg_wen   = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    enc_a_raw = 2'b10;
    enc_b_raw = 2'b10;
    reg_wen   = 1'b0;
    reg_raddr = '0;
    reg_waddr = '0;
    reg_wdata = '0;
    tick; tick;
    check("rst_afilt", enc_a_filt, 2'b00);
    check("rst_bfilt", enc_b_filt, 2'b00);
    check("rst_err", enc_err, 2'b00);

    // Start-up: filters preload on the third edge after reset release
    reset = 1'b0;
    tick; tick;
    check("init_afilt_e2", enc_a_filt, 2'b00);
    tick;
    check("load_afilt_e3", enc_a_filt, 2'b10);
    check("load_bfilt_e3", enc_b_filt, 2'b10);
    check("load_err", enc_err, 2'b00);
    chk_reg("stat1_init", 4'd1, OFF_ENC_STAT, 32'h0);
    chk_reg("stat2_init", 4'd2, OFF_ENC_STAT, 32'h0);
    chk_reg("filt_default", 4'd0, OFF_ENC_FILT, 32'h7);
    chk_reg("bad_offset", 4'd1, 4'h3, 32'h0);

    // N=7: ch2 A rises, filter output follows at edge 9
    enc_a_raw[2] = 1'b1;
    tick;
    for (int k = 1; k <= 9; k++) begin
      tick;
      check($sformatf("n7_rise_e%0d", k), enc_a_filt, (k >= 9) ? 2'b11 : 2'b10);
    end

    // 5-cycle low pulse is rejected and counted as one glitch
    enc_a_raw[2] = 1'b0;
    repeat (5) tick;
    enc_a_raw[2] = 1'b1;
    repeat (4) tick;
    check("glitch_filt_held", enc_a_filt, 2'b11);
    chk_reg("glitch_stat2", 4'd2, OFF_ENC_STAT, 32'h0000_0001);
    chk_reg("glitch_stat1", 4'd1, OFF_ENC_STAT, 32'h0);

    // N=0: two-edge latency
    wr(4'd0, OFF_ENC_FILT, 32'h0);
    chk_reg("filt_rd0", 4'd0, OFF_ENC_FILT, 32'h0);
    enc_a_raw[2] = 1'b0;
    tick;
    tick;
    check("n0_e1", enc_a_filt, 2'b11);
    tick;
    check("n0_e2", enc_a_filt, 2'b10);

    // N=12, raised to 15 while count is 10: update lands at edge 17
    wr(4'd0, OFF_ENC_FILT, 32'd12);
    enc_a_raw[2] = 1'b1;
    tick;
    repeat (10) tick;
    wr(4'd0, OFF_ENC_FILT, 32'd15);
    for (int k = 12; k <= 17; k++) begin
      tick;
      check($sformatf("n15_e%0d", k), enc_a_filt, (k >= 17) ? 2'b11 : 2'b10);
    end

    // Illegal transition on ch2: A and B toggle together with N=0
    wr(4'd0, OFF_ENC_FILT, 32'h0);
    wr(4'd2, OFF_ENC_STAT, 32'h1);
    chk_reg("stat2_cleared", 4'd2, OFF_ENC_STAT, 32'h0);
    enc_a_raw[2] = 1'b0;
    enc_b_raw[2] = 1'b1;
    tick;
    tick;
    check("ill_err_e1", enc_err, 2'b00);
    tick;
    check("ill_err_e2", enc_err, 2'b01);
    check("ill_afilt_e2", enc_a_filt, 2'b10);
    check("ill_bfilt_e2", enc_b_filt, 2'b11);
    tick;
    check("ill_err_e3", enc_err, 2'b00);
    chk_reg("ill_stat2", 4'd2, OFF_ENC_STAT, 32'h8001_0000);

    // 300 more illegal events saturate the counter
    for (int i = 0; i < 300; i++) begin
      enc_a_raw[2] = ~enc_a_raw[2];
      enc_b_raw[2] = ~enc_b_raw[2];
      repeat (3) tick;
    end
    repeat (2) tick;
    chk_reg("ill_sat", 4'd2, OFF_ENC_STAT, 32'h80FF_0000);

    // Clear coincident with an illegal event keeps that event
    enc_a_raw[2] = ~enc_a_raw[2];
    enc_b_raw[2] = ~enc_b_raw[2];
    tick;
    tick;
    wr(4'd2, OFF_ENC_STAT, 32'h1);
    check("clr_evt_err", enc_err, 2'b01);
    chk_reg("clr_evt_stat", 4'd2, OFF_ENC_STAT, 32'h8001_0000);
    tick;
    check("clr_evt_err_off", enc_err, 2'b00);

    // Reset in the middle of a filter count
    wr(4'd0, OFF_ENC_FILT, 32'd5);
    enc_a_raw[2] = ~enc_a_raw[2];
    repeat (5) tick;
    reset = 1'b1;
    #1;
    check("mid_rst_afilt", enc_a_filt, 2'b00);
    check("mid_rst_bfilt", enc_b_filt, 2'b00);
    check("mid_rst_err", enc_err, 2'b00);
    tick;
    chk_reg("mid_rst_stat2", 4'd2, OFF_ENC_STAT, 32'h0);
    chk_reg("mid_rst_filt", 4'd0, OFF_ENC_FILT, 32'h7);
    reset = 1'b0;
    tick;
    tick;
    check("rerun_e2", enc_a_filt, 2'b00);
    tick;
    check("rerun_a_e3", enc_a_filt, 2'b10);
    check("rerun_b_e3", enc_b_filt, 2'b10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
